// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared encodings for the MEM-stage load/store unit
// Contents: funct3 access encodings, FSM state encoding, fault-cause codes
//           (also consumed by the trap controller), and the access classifier.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        CAUSE_NONE             = 2'd0,
        CAUSE_LOAD_MISALIGNED  = 2'd1,
        CAUSE_STORE_MISALIGNED = 2'd2,
        CAUSE_ACCESS_FAULT     = 2'd3
    } fault_cause_t;

    // Illegal encodings / conflicting controls outrank misalignment.
    // Access size comes from funct3[1:0], so BU/HU share the B/H alignment rules.
    function automatic fault_cause_t classify_access(
        input logic       rd,
        input logic       wr,
        input logic [2:0] funct3,
        input logic [1:0] offset
    );
        fault_cause_t cause;
        cause = CAUSE_NONE;
        if ((rd && wr) || funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) begin
            cause = CAUSE_ACCESS_FAULT;
        end else if ((funct3[1:0] == 2'b01 && offset[0]) ||
                     (funct3[1:0] == 2'b10 && offset != 2'b00)) begin
            cause = rd ? CAUSE_LOAD_MISALIGNED : CAUSE_STORE_MISALIGNED;
        end
        return cause;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// rtl/lsu_data_align.sv - store lane replication/strobes and load byte/half extraction
// Ports: store_funct3/store_offset/store_data -> wdata, wstrb (purely combinational)
//        load_funct3/load_offset/rdata        -> load_value (sign/zero extended)
module lsu_data_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  store_funct3,
    input  logic [1:0]  store_offset,
    input  logic [31:0] store_data,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic [2:0]  load_funct3,
    input  logic [1:0]  load_offset,
    input  logic [31:0] rdata,
    output logic [31:0] load_value
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    always_comb begin
        wdata = store_data;
        wstrb = 4'b1111;
        case (store_funct3[1:0])
            2'b00: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << store_offset;
            end
            2'b01: begin
                wdata = {2{store_data[15:0]}};
                wstrb = store_offset[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wdata = store_data;
                wstrb = 4'b1111;
            end
        endcase
    end

    assign load_byte = rdata[{load_offset, 3'b000} +: 8];
    assign load_half = rdata[{load_offset[1], 4'b0000} +: 16];

    always_comb begin
        load_value = rdata;
        case (load_funct3)
            F3_B:    load_value = {{24{load_byte[7]}}, load_byte};
            F3_H:    load_value = {{16{load_half[15]}}, load_half};
            F3_BU:   load_value = {24'd0, load_byte};
            F3_HU:   load_value = {16'd0, load_half};
            default: load_value = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage data-memory access FSM with stall and fault reporting
// Ports: MEM_* controls from EX/MEM in; dmem_req/write/addr/wdata/wstrb registered bus
//        request out, dmem_rdata/dmem_ready bus response in; MEM_load_data result,
//        mem_stall hold request, load_misaligned/store_misaligned/access_fault pulses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TIMER_WIDTH    = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MEM_memory_read,
    input  logic            MEM_memory_write,
    input  logic [2:0]      MEM_funct3,
    input  logic [XLEN-1:0] MEM_alu_result,
    input  logic [XLEN-1:0] MEM_read_data2,
    output logic            dmem_req,
    output logic            dmem_write,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [3:0]      dmem_wstrb,
    input  logic [XLEN-1:0] dmem_rdata,
    input  logic            dmem_ready,
    output logic [XLEN-1:0] MEM_load_data,
    output logic            mem_stall,
    output logic            load_misaligned,
    output logic            store_misaligned,
    output logic            access_fault
);

    localparam logic [TIMER_WIDTH-1:0] TIMER_LAST = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

    lsu_state_t             state;
    logic [TIMER_WIDTH-1:0] timer;
    logic [2:0]             ld_funct3;
    logic [1:0]             ld_offset;

    logic                   access;
    fault_cause_t           cause;
    logic [XLEN-1:0]        align_wdata;
    logic [3:0]             align_wstrb;
    logic [XLEN-1:0]        align_load;

    assign access    = MEM_memory_read | MEM_memory_write;
    assign cause     = classify_access(MEM_memory_read, MEM_memory_write,
                                       MEM_funct3, MEM_alu_result[1:0]);
    assign mem_stall = ((state == IDLE) && access) || (state == REQ);

    // Store side sees the live request; load side uses the offset/size latched
    // at request time so extraction matches the word the bus returns.
    lsu_data_align u_align (
        .store_funct3 (MEM_funct3),
        .store_offset (MEM_alu_result[1:0]),
        .store_data   (MEM_read_data2),
        .wdata        (align_wdata),
        .wstrb        (align_wstrb),
        .load_funct3  (ld_funct3),
        .load_offset  (ld_offset),
        .rdata        (dmem_rdata),
        .load_value   (align_load)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            timer            <= '0;
            ld_funct3        <= '0;
            ld_offset        <= '0;
            dmem_req         <= 1'b0;
            dmem_write       <= 1'b0;
            dmem_addr        <= '0;
            dmem_wdata       <= '0;
            dmem_wstrb       <= '0;
            MEM_load_data    <= '0;
            load_misaligned  <= 1'b0;
            store_misaligned <= 1'b0;
            access_fault     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (access) begin
                        if (cause == CAUSE_NONE) begin
                            dmem_req   <= 1'b1;
                            dmem_write <= MEM_memory_write;
                            dmem_addr  <= {MEM_alu_result[XLEN-1:2], 2'b00};
                            dmem_wdata <= MEM_memory_write ? align_wdata : '0;
                            dmem_wstrb <= MEM_memory_write ? align_wstrb : 4'b0000;
                            ld_funct3  <= MEM_funct3;
                            ld_offset  <= MEM_alu_result[1:0];
                            timer      <= '0;
                            state      <= REQ;
                        end else begin
                            load_misaligned  <= (cause == CAUSE_LOAD_MISALIGNED);
                            store_misaligned <= (cause == CAUSE_STORE_MISALIGNED);
                            access_fault     <= (cause == CAUSE_ACCESS_FAULT);
                            MEM_load_data    <= '0;
                            state            <= DONE;
                        end
                    end
                end
                REQ: begin
                    if (dmem_ready) begin
                        dmem_req      <= 1'b0;
                        MEM_load_data <= dmem_write ? '0 : align_load;
                        state         <= DONE;
                    end else if (timer == TIMER_LAST) begin
                        dmem_req      <= 1'b0;
                        access_fault  <= 1'b1;
                        MEM_load_data <= '0;
                        state         <= DONE;
                    end else begin
                        timer <= timer + TIMER_WIDTH'(1);
                    end
                end
                DONE: begin
                    load_misaligned  <= 1'b0;
                    store_misaligned <= 1'b0;
                    access_fault     <= 1'b0;
                    state            <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        MEM_memory_read, MEM_memory_write;
    logic [2:0]  MEM_funct3;
    logic [31:0] MEM_alu_result, MEM_read_data2;
    logic        dmem_req, dmem_write;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic [31:0] MEM_load_data;
    logic        mem_stall, load_misaligned, store_misaligned, access_fault;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk              (clk),
        .reset            (reset),
        .MEM_memory_read  (MEM_memory_read),
        .MEM_memory_write (MEM_memory_write),
        .MEM_funct3       (MEM_funct3),
        .MEM_alu_result   (MEM_alu_result),
        .MEM_read_data2   (MEM_read_data2),
        .dmem_req         (dmem_req),
        .dmem_write       (dmem_write),
        .dmem_addr        (dmem_addr),
        .dmem_wdata       (dmem_wdata),
        .dmem_wstrb       (dmem_wstrb),
        .dmem_rdata       (dmem_rdata),
        .dmem_ready       (dmem_ready),
        .MEM_load_data    (MEM_load_data),
        .mem_stall        (mem_stall),
        .load_misaligned  (load_misaligned),
        .store_misaligned (store_misaligned),
        .access_fault     (access_fault)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        MEM_memory_read  = 1'b0;
        MEM_memory_write = 1'b0;
        MEM_funct3       = 3'b000;
        MEM_alu_result   = 32'd0;
        MEM_read_data2   = 32'd0;
    endtask

    // One instruction through the unit. lat = number of REQ cycles with ready low
    // before ready is raised; lat >= 16 means the bus never answers.
    task automatic run_txn(input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] data,
                           input logic [31:0] rword, input int lat);
        int          off, size, nreq, stalls;
        bit          af, lmis, smis, timeout;
        logic [31:0] b, h, exp_ld, exp_wd;
        logic [3:0]  exp_st;

        off  = int'(addr % 4);
        size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        af   = (rd && wr) || f3 == 3 || f3 == 6 || f3 == 7;
        lmis = !af && rd && ((size == 2 && off % 2 != 0) || (size == 4 && off != 0));
        smis = !af && wr && ((size == 2 && off % 2 != 0) || (size == 4 && off != 0));
        timeout = (lat >= 16);
        nreq = timeout ? 16 : lat + 1;

        b = (rword >> (8 * off)) & 32'hFF;
        h = (rword >> (16 * (off / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    exp_ld = (b >= 128) ? b - 32'd256 : b;
            3'd1:    exp_ld = (h >= 32768) ? h - 32'd65536 : h;
            3'd4:    exp_ld = b;
            3'd5:    exp_ld = h;
            default: exp_ld = rword;
        endcase
        if (wr || timeout) exp_ld = 32'd0;
        if (size == 1) begin
            exp_wd = (data & 32'hFF) * 32'h01010101;
            exp_st = 4'(1 << off);
        end else if (size == 2) begin
            exp_wd = (data & 32'hFFFF) * 32'h00010001;
            exp_st = (off >= 2) ? 4'hC : 4'h3;
        end else begin
            exp_wd = data;
            exp_st = 4'hF;
        end

        @(posedge clk); #1;
        MEM_memory_read  = rd;
        MEM_memory_write = wr;
        MEM_funct3       = f3;
        MEM_alu_result   = addr;
        MEM_read_data2   = data;
        dmem_ready       = 1'($urandom);
        dmem_rdata       = $urandom;
        stalls = 0;

        @(negedge clk);
        check("idle_req", dmem_req, 0);
        check("idle_stall", mem_stall, rd || wr);
        if (mem_stall) stalls++;
        if (!(rd || wr)) begin
            @(posedge clk); #1;
            clear_inputs();
            dmem_ready = 1'b0;
            @(negedge clk);
            check("noacc_req", dmem_req, 0);
            return;
        end

        if (!(af || lmis || smis)) begin
            for (int i = 1; i <= nreq; i++) begin
                @(posedge clk); #1;
                dmem_ready = (i == lat + 1);
                dmem_rdata = (i == lat + 1) ? rword : $urandom;
                @(negedge clk);
                if (mem_stall) stalls++;
                check("req_req", dmem_req, 1);
                check("req_write", dmem_write, wr);
                check("req_addr", dmem_addr, {addr[31:2], 2'b00});
                check("req_wstrb", dmem_wstrb, wr ? exp_st : 4'h0);
                if (wr) check("req_wdata", dmem_wdata, exp_wd);
            end
        end

        // DONE: ready noise must be ignored, inputs still show the same instruction
        @(posedge clk); #1;
        dmem_ready = 1'($urandom);
        dmem_rdata = $urandom;
        @(negedge clk);
        if (mem_stall) stalls++;
        check("stall_cycles", stalls, (af || lmis || smis) ? 1 : 1 + nreq);
        check("done_stall", mem_stall, 0);
        check("done_req", dmem_req, 0);
        check("done_lmis", load_misaligned, lmis);
        check("done_smis", store_misaligned, smis);
        check("done_afault", access_fault, af || (timeout && !(lmis || smis)));
        if (!(af || lmis || smis)) check("done_load", MEM_load_data, exp_ld);

        @(posedge clk); #1;
        clear_inputs();
        dmem_ready = 1'b0;
        @(negedge clk);
        check("after_flags", {load_misaligned, store_misaligned, access_fault}, 0);
        check("after_stall", mem_stall, 0);
        check("after_req", dmem_req, 0);
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        dmem_ready = 1'b0;
        dmem_rdata = 32'd0;
        #12;
        check("rst_req", dmem_req, 0);
        check("rst_write", dmem_write, 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wdata", dmem_wdata, 0);
        check("rst_wstrb", dmem_wstrb, 0);
        check("rst_load", MEM_load_data, 0);
        check("rst_flags", {load_misaligned, store_misaligned, access_fault}, 0);
        check("rst_stall", mem_stall, 0);
        reset = 1'b1;

        run_txn(0, 1, 3'b010, 32'h1000_0040, 32'hDEADBEEF, 32'h0, 0);
        run_txn(1, 0, 3'b000, 32'h2000_0033, 32'h0, 32'h80FF_1234, 0);
        run_txn(1, 0, 3'b100, 32'h2000_0033, 32'h0, 32'h80FF_1234, 1);
        run_txn(1, 0, 3'b101, 32'h2000_0032, 32'h0, 32'h80FF_1234, 0);
        run_txn(0, 1, 3'b000, 32'h0000_0002, 32'h0000_00A5, 32'h0, 0);
        run_txn(0, 1, 3'b001, 32'h0000_0002, 32'h0000_00A5, 32'h0, 0);
        run_txn(1, 0, 3'b010, 32'h0000_0006, 32'h0, 32'h0, 0);
        run_txn(1, 1, 3'b010, 32'h0000_0008, 32'h0, 32'h0, 0);
        run_txn(1, 0, 3'b010, 32'h0000_0010, 32'h0, 32'h1234_5678, 99);
        run_txn(1, 0, 3'b010, 32'h0000_0010, 32'h0, 32'h1234_5678, 2);
        run_txn(1, 0, 3'b010, 32'h0000_0014, 32'h0, 32'hCAFE_F00D, 15);
        run_txn(0, 1, 3'b111, 32'h0000_0014, 32'h1, 32'h0, 0);

        for (int n = 0; n < 200; n++) begin
            int  kind, lat;
            bit  rd, wr;
            kind = $urandom_range(0, 19);
            rd = (kind == 0) || (kind >= 2 && kind < 11);
            wr = (kind == 0) || (kind >= 11);
            lat = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 5);
            run_txn(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, lat);
        end

        // Asynchronous reset in the middle of an outstanding store
        @(posedge clk); #1;
        MEM_memory_write = 1'b1;
        MEM_funct3       = 3'b010;
        MEM_alu_result   = 32'h0000_0100;
        MEM_read_data2   = 32'h1111_2222;
        @(posedge clk); #1;
        @(negedge clk);
        check("mid_req_before", dmem_req, 1);
        #1 clear_inputs();
        #1 reset = 1'b0;
        #1;
        check("arst_req", dmem_req, 0);
        check("arst_addr", dmem_addr, 0);
        check("arst_wdata", dmem_wdata, 0);
        check("arst_wstrb", dmem_wstrb, 0);
        check("arst_stall", mem_stall, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        dmem_ready = 1'b1;
        dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        @(negedge clk);
        check("late_req", dmem_req, 0);
        check("late_load", MEM_load_data, 0);
        check("late_flags", {load_misaligned, store_misaligned, access_fault}, 0);
        check("late_stall", mem_stall, 0);

        run_txn(1, 0, 3'b001, 32'h0000_0202, 32'h0, 32'h8001_7FFF, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
